// File: rtl/icache_fill_controller.sv
// Page-tag owner and refill sequencer for the single-page instruction cache.
// A miss streams the whole page from the memory bus as 64-bit beats, then commits the tag.
module icache_fill_controller #(
   parameter int PAGE_BITS = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_valid,
   input  logic [63:0]           fetch_pc,
   input  logic                  flush,
   output logic                  icache_r,
   output logic                  busy,
   output logic [63-PAGE_BITS:0] tag,
   output logic                  tag_valid,
   output logic                  fill_we,
   output logic [PAGE_BITS-1:0]  fill_addr,
   output logic [63:0]           fill_data,
   output logic                  mem_req,
   output logic [63:0]           mem_addr,
   input  logic                  mem_ack,
   input  logic [63:0]           mem_rdata,
   output logic [31:0]           miss_count
);

   localparam int BW    = PAGE_BITS - 3;
   localparam int TW    = 64 - PAGE_BITS;
   localparam int BEATS = 2 ** BW;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [TW-1:0]   r_tag;
   logic            r_tag_valid;
   logic [TW-1:0]   r_fill_tag;
   logic [BW-1:0]   r_beat_idx;
   logic            r_flush_pending;
   logic            r_mem_req;
   logic [63:0]     r_mem_addr;
   logic            r_fill_we;
   logic [PAGE_BITS-1:0] r_fill_addr;
   logic [63:0]     r_fill_data;
   logic [31:0]     r_miss_count;

   logic            w_hit;
   logic            w_start;
   logic            w_beat_ack;
   logic            w_last_ack;
   logic            w_commit;
   logic [BW-1:0]   w_beat_inc;
   logic [TW-1:0]   w_pc_tag;
   logic            w_unused;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign w_pc_tag   = fetch_pc[63:PAGE_BITS];
   assign w_hit      = r_tag_valid && (w_pc_tag == r_tag);
   assign w_beat_inc = r_beat_idx + 1'b1;
   assign w_unused   = ^fetch_pc[PAGE_BITS-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_beat_ack  = 1'b0;
      w_last_ack  = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (fetch_valid && !w_hit && !flush) begin
               w_start     = 1'b1;
               w_state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            if (mem_ack) begin
               w_beat_ack = 1'b1;
               if (r_beat_idx == LAST_BEAT) begin
                  w_last_ack  = 1'b1;
                  w_state_nxt = S_COMMIT;
               end
            end
         end
         S_COMMIT: begin
            w_commit    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tag           <= '0;
         r_tag_valid     <= 1'b0;
         r_fill_tag      <= '0;
         r_beat_idx      <= '0;
         r_flush_pending <= 1'b0;
         r_mem_req       <= 1'b0;
         r_mem_addr      <= '0;
         r_fill_we       <= 1'b0;
         r_fill_addr     <= '0;
         r_fill_data     <= '0;
         r_miss_count    <= '0;
      end else begin
         // Write-back of an acked beat lands on the array one cycle later
         r_fill_we <= w_beat_ack;
         if (w_beat_ack) begin
            r_fill_addr <= {r_beat_idx, 3'b000};
            r_fill_data <= mem_rdata;
         end

         if (w_start) begin
            r_fill_tag      <= w_pc_tag;
            r_beat_idx      <= '0;
            r_mem_req       <= 1'b1;
            r_mem_addr      <= {w_pc_tag, {BW{1'b0}}, 3'b000};
            r_tag_valid     <= 1'b0;
            r_flush_pending <= 1'b0;
            r_miss_count    <= sat_inc32(r_miss_count);
         end else if (w_beat_ack) begin
            if (w_last_ack) begin
               r_mem_req <= 1'b0;
            end else begin
               r_beat_idx <= w_beat_inc;
               r_mem_addr <= {r_fill_tag, w_beat_inc, 3'b000};
            end
         end

         if (flush) begin
            if (r_state == S_IDLE) begin
               r_tag_valid <= 1'b0;
            end else begin
               r_flush_pending <= 1'b1;
            end
         end

         // A flush seen anywhere during the fill leaves the new page invalid
         if (w_commit) begin
            r_tag           <= r_fill_tag;
            r_tag_valid     <= !r_flush_pending && !flush;
            r_flush_pending <= 1'b0;
         end
      end
   end

   assign icache_r   = w_hit;
   assign busy       = (r_state != S_IDLE);
   assign tag        = r_tag;
   assign tag_valid  = r_tag_valid;
   assign fill_we    = r_fill_we;
   assign fill_addr  = r_fill_addr;
   assign fill_data  = r_fill_data;
   assign mem_req    = r_mem_req;
   assign mem_addr   = r_mem_addr;
   assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_fill_controller.sv
// Directed bench for icache_fill_controller: fills, stalls, flush, reset abort and redirect.
module tb_icache_fill_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_valid;
   logic [63:0] fetch_pc;
   logic        flush;
   logic        icache_r;
   logic        busy;
   logic [51:0] tag;
   logic        tag_valid;
   logic        fill_we;
   logic [11:0] fill_addr;
   logic [63:0] fill_data;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [63:0] mem_rdata;
   logic [31:0] miss_count;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          n_writes = 0;
   int          exp_beat = 0;
   int          g_ack_period = 1;
   logic [51:0] exp_tag = '0;
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic [63:0] prev_addr = '0;
   logic [63:0] q_addr[$];
   logic [63:0] q_data[$];

   icache_fill_controller #(.PAGE_BITS(12)) dut (
      .clk        (clk),
      .reset      (reset),
      .fetch_valid(fetch_valid),
      .fetch_pc   (fetch_pc),
      .flush      (flush),
      .icache_r   (icache_r),
      .busy       (busy),
      .tag        (tag),
      .tag_valid  (tag_valid),
      .fill_we    (fill_we),
      .fill_addr  (fill_addr),
      .fill_data  (fill_data),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, obs, exp, cyc);
      end
   endtask

   // One clock: observe outputs after the edge, then drive this cycle's memory response
   task automatic step();
      logic [63:0] ea;
      logic [63:0] ed;
      @(posedge clk);
      #1;
      cyc++;
      if (!reset && prev_req && !prev_ack) begin
         check("req_hold", 64'(mem_req), 64'd1);
         check("addr_hold", mem_addr, prev_addr);
      end
      if (fill_we) begin
         n_writes++;
         check("we_while_busy", 64'(busy), 64'd1);
         check("we_queued", 64'(q_addr.size() != 0), 64'd1);
         if (q_addr.size() != 0) begin
            ea = q_addr.pop_front();
            ed = q_data.pop_front();
            check("fill_addr", 64'(fill_addr), ea);
            check("fill_data", fill_data, ed);
         end
      end
      mem_rdata = {32'(cyc) ^ 32'h5A5A_0000, mem_addr[31:0] ^ 32'hC0DE_F00D};
      mem_ack   = mem_req && ((cyc % g_ack_period) == 0);
      if (mem_ack) begin
         check("mem_addr", mem_addr, {exp_tag, 9'(exp_beat), 3'b000});
         q_addr.push_back({52'd0, 9'(exp_beat), 3'b000});
         q_data.push_back(mem_rdata);
         exp_beat++;
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
      prev_ack  = mem_ack;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      mem_ack = 1'b0;
      q_addr.delete();
      q_data.delete();
      step();
      reset    = 1'b0;
      exp_beat = 0;
      n_writes = 0;
   endtask

   task automatic run_until_hit(input int bound, output int k);
      k = 0;
      do begin
         step();
         k++;
      end while (!icache_r && k < bound);
      check("hit_reached", 64'(icache_r), 64'd1);
   endtask

   task automatic run_until_idle(input int bound);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (busy && k < bound);
      check("idle_reached", 64'(busy), 64'd0);
   endtask

   task automatic run_until_beat(input int beat, input int bound);
      int k;
      k = 0;
      while (exp_beat < beat && k < bound) begin
         step();
         k++;
      end
      check("beat_reached", 64'(exp_beat >= beat), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      reset       = 1'b1;
      fetch_valid = 1'b0;
      fetch_pc    = '0;
      flush       = 1'b0;
      mem_ack     = 1'b0;
      mem_rdata   = '0;

      // Reset state
      do_reset();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_tag", 64'(tag), 64'd0);
      check("rst_tag_valid", 64'(tag_valid), 64'd0);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_fill_we", 64'(fill_we), 64'd0);
      check("rst_fill_addr", 64'(fill_addr), 64'd0);
      check("rst_fill_data", fill_data, 64'd0);
      check("rst_miss_count", 64'(miss_count), 64'd0);
      check("rst_icache_r", 64'(icache_r), 64'd0);

      // Full fill of page 0x1 with ack tied high: 514 cycles miss-to-hit
      fetch_valid = 1'b1;
      fetch_pc    = 64'h0000_0000_0000_1004;
      exp_tag     = 52'h1;
      exp_beat    = 0;
      n_writes    = 0;
      run_until_hit(600, k);
      check("t1_latency", 64'(k), 64'd514);
      check("t1_writes", 64'(n_writes), 64'd512);
      check("t1_acks", 64'(exp_beat), 64'd512);
      check("t1_tag", 64'(tag), 64'h1);
      check("t1_miss_count", 64'(miss_count), 64'd1);

      // Same-page PC hits; next page misses
      fetch_pc = 64'h1FFC;
      #1;
      check("t2_hit_1ffc", 64'(icache_r), 64'd1);
      step();
      check("t2_no_req", 64'(mem_req), 64'd0);
      check("t2_not_busy", 64'(busy), 64'd0);
      fetch_pc = 64'h2000;
      #1;
      check("t2_miss_2000", 64'(icache_r), 64'd0);
      exp_tag  = 52'h2;
      exp_beat = 0;
      n_writes = 0;
      step();
      check("t2_req", 64'(mem_req), 64'd1);
      check("t2_first_addr", mem_addr, 64'h2000);
      check("t2_miss_count", 64'(miss_count), 64'd2);
      run_until_hit(600, k);
      check("t2_tag", 64'(tag), 64'h2);
      check("t2_writes", 64'(n_writes), 64'd512);

      // Ack only every third cycle: holds are checked inside step()
      fetch_pc     = 64'h7000;
      exp_tag      = 52'h7;
      exp_beat     = 0;
      n_writes     = 0;
      g_ack_period = 3;
      run_until_hit(3000, k);
      check("t3_writes", 64'(n_writes), 64'd512);
      check("t3_tag", 64'(tag), 64'h7);
      check("t3_miss_count", 64'(miss_count), 64'd3);
      g_ack_period = 1;

      // Flush at beat 100: tag updates but stays invalid, then re-miss
      fetch_pc = 64'h8000;
      exp_tag  = 52'h8;
      exp_beat = 0;
      n_writes = 0;
      run_until_beat(100, 400);
      flush = 1'b1;
      step();
      flush = 1'b0;
      run_until_idle(1000);
      check("t4_tag", 64'(tag), 64'h8);
      check("t4_tag_valid", 64'(tag_valid), 64'd0);
      check("t4_icache_r", 64'(icache_r), 64'd0);
      check("t4_writes", 64'(n_writes), 64'd512);
      exp_beat = 0;
      n_writes = 0;
      step();
      check("t4_remiss_busy", 64'(busy), 64'd1);
      check("t4_remiss_count", 64'(miss_count), 64'd5);

      // Reset at beat 37 aborts the fill; next miss restarts at beat 0
      run_until_beat(37, 400);
      do_reset();
      check("t5_mem_req", 64'(mem_req), 64'd0);
      check("t5_fill_we", 64'(fill_we), 64'd0);
      check("t5_tag_valid", 64'(tag_valid), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_miss_count", 64'(miss_count), 64'd0);
      exp_tag = 52'h8;
      run_until_hit(600, k);
      check("t5_latency", 64'(k), 64'd514);
      check("t5_writes", 64'(n_writes), 64'd512);
      check("t5_miss_count_after", 64'(miss_count), 64'd1);

      // Flush in IDLE with a simultaneous miss: no fill, page invalidated
      fetch_pc = 64'h9000;
      flush    = 1'b1;
      step();
      flush = 1'b0;
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_tag_valid", 64'(tag_valid), 64'd0);
      check("t6_miss_count", 64'(miss_count), 64'd1);
      fetch_valid = 1'b0;
      step();
      check("t6_still_idle", 64'(busy), 64'd0);

      // Redirect to 0x5000 mid-fill of page 0x3 is ignored until commit
      fetch_valid = 1'b1;
      fetch_pc    = 64'h3000;
      exp_tag     = 52'h3;
      exp_beat    = 0;
      n_writes    = 0;
      run_until_beat(50, 400);
      fetch_pc = 64'h5000;
      run_until_idle(1000);
      check("t7_tag", 64'(tag), 64'h3);
      check("t7_tag_valid", 64'(tag_valid), 64'd1);
      check("t7_writes", 64'(n_writes), 64'd512);
      check("t7_icache_r", 64'(icache_r), 64'd0);
      check("t7_miss_count", 64'(miss_count), 64'd2);
      exp_tag  = 52'h5;
      exp_beat = 0;
      step();
      check("t7_new_busy", 64'(busy), 64'd1);
      check("t7_new_req", 64'(mem_req), 64'd1);
      check("t7_new_addr", mem_addr, 64'h5000);
      check("t7_new_miss_count", 64'(miss_count), 64'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_fill_controller.md
Name: icache_fill_controller

Overview:
- Owns the page tag of the single-page instruction cache and sequences page refills from the memory bus.
- Detects a miss (fetch PC page != resident page), streams the full page from memory as 64-bit beats into the cache byte array, commits the new tag, and drives the hit/ready signal back to fetch.
- Sits between the fetch stage, the instruction cache storage and the memory bus.

Parameters:
- PAGE_BITS, 12, log2 of page size in bytes; the tag is PC[63:PAGE_BITS].
- BEATS, 2**(PAGE_BITS-3), number of 64-bit beats per page (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch presents a valid PC this cycle.
- fetch_pc  in  64  fetch PC.
- flush  in  1  one-cycle pulse that invalidates the resident page.
- icache_r  out  1  hit: tag_valid && fetch_pc[63:PAGE_BITS]==tag (combinational).
- busy  out  1  FSM not in IDLE.
- tag  out  64-PAGE_BITS  resident page tag.
- tag_valid  out  1  resident page valid.
- fill_we  out  1  write strobe to the cache byte array (8 bytes).
- fill_addr  out  PAGE_BITS  byte offset of the beat; low 3 bits are 0.
- fill_data  out  64  beat data, little-endian; byte 0 goes to fill_addr.
- mem_req  out  1  read request, held until acked.
- mem_addr  out  64  {fill_tag, beat_idx, 3'b000}.
- mem_ack  in  1  beat accepted; mem_rdata valid this cycle.
- mem_rdata  in  64  read data.
- miss_count  out  32  number of refills started, saturating at 32'hFFFF_FFFF.

Behaviour:
- Reset values: state=IDLE, tag=0, tag_valid=0, mem_req=0, mem_addr=0, fill_we=0, fill_addr=0, fill_data=0, miss_count=0, beat_idx=0, flush_pending=0. Reset mid-fill aborts immediately: mem_req drops the next cycle, tag_valid=0, and no commit occurs.
- States:
  - IDLE -> FILL when fetch_valid && !icache_r && !flush. At that edge: fill_tag <= fetch_pc[63:PAGE_BITS], beat_idx <= 0, miss_count++.
  - FILL: mem_req=1 and mem_addr={fill_tag, beat_idx, 000}, both registered. On mem_ack: capture mem_rdata; next cycle fill_we=1, fill_addr={beat_idx_acked, 000}, fill_data=captured. beat_idx increments, and mem_req stays high for the next beat with no bubble. On the ack of beat BEATS-1: mem_req=0 next cycle, -> COMMIT.
  - COMMIT (1 cycle): fill_we for the last beat; at the end edge tag <= fill_tag, tag_valid <= !flush_pending && !flush, flush_pending <= 0; -> IDLE.
- fill_we is 1 only in the cycle after an ack, never in IDLE.
- mem_addr and mem_req must not change while mem_req=1 && !mem_ack.
- Latency with mem_ack tied high:
  - miss cycle N, beats acked N+1..N+BEATS, COMMIT at N+BEATS+1, icache_r=1 at N+BEATS+2.
  - Default config: 514 cycles miss-to-hit.
- fetch_pc and fetch_valid changes during FILL/COMMIT are ignored. The fill always completes for the captured page, with no abort on redirect. icache_r during FILL reflects the old tag, and tag_valid is forced to 0 from entry into FILL until commit.
- flush:
  - In IDLE: tag_valid <= 0 next cycle; no fill starts that cycle even on a miss.
  - In FILL/COMMIT: sets flush_pending, so the commit writes the tag with tag_valid=0.
- Wrap: beat_idx is PAGE_BITS-3 bits wide; beat BEATS-1 is the terminal beat, with no wrap to 0 within a fill.
- miss_count holds at all-ones once saturated.

Test Plan:
- Reset, then fetch_valid=1, fetch_pc=64'h0000_0000_0000_1004, mem_ack=1 every cycle -> mem_addr steps 0x1000, 0x1008 … 0x1FF8; 512 fill_we pulses with fill_addr 0x000..0xFF8; icache_r=1 exactly 514 cycles after the miss; tag=52'h1, miss_count=1.
- After that fill, fetch_pc=0x1FFC -> icache_r=1, no mem_req; fetch_pc=0x2000 -> miss, mem_addr starts 0x2000, miss_count=2.
- mem_ack asserted only every 3rd cycle -> mem_addr and mem_req stable while unacked; fill_data for beat k equals the mem_rdata on its ack; still exactly 512 writes.
- flush pulse at beat 100 of a fill -> fill completes and tag updates, but tag_valid=0 and icache_r=0 after COMMIT; the next fetch re-misses.
- reset asserted at beat 37 -> next cycle mem_req=0, fill_we=0, tag_valid=0, busy=0; the following miss restarts at beat 0.
- fetch_pc changed to 0x5000 mid-fill of page 0x3 -> fill still targets 0x3000..0x3FF8; after commit tag=0x3, then a new fill for 0x5000 begins.
